// File: rtl/sigma_pkg.sv
// Shared types and constants for the sigma_16p serial output path.
// Holds the byte-level FSM state type, the data widths and the frame byte mapping.
package sigma_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int SUM_W       = 12;
    localparam int BYTE_W      = 8;
    localparam int FRAME_BYTES = 2;

    localparam logic [3:0] HDR_DEFAULT = 4'hA;

    // Byte 0 carries the header and the top nibble (sign included), byte 1 the low byte.
    function automatic logic [BYTE_W-1:0] frame_byte(
        input logic [3:0]       hdr,
        input logic [SUM_W-1:0] sum,
        input logic             sel
    );
        frame_byte = sel ? sum[BYTE_W-1:0] : {hdr, sum[SUM_W-1:BYTE_W]};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART 8N1 serialiser: baud counter plus START/DATA/STOP sequencing.
// A start request during the last STOP cycle chains the next byte with no idle bit.
module uart_byte_tx
    import sigma_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              res,
    input  logic              start,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              tx,
    output logic              idle,
    output logic              done
);

    localparam int              CNT_W     = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

    tx_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  baud_reg, baud_next;
    logic [2:0]        bit_reg, bit_next;
    logic [BYTE_W-1:0] shift_reg, shift_next;
    logic              last_tick;

    assign last_tick = (baud_reg == BAUD_LAST);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        baud_next  = last_tick ? '0 : baud_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        case (state_reg)
            IDLE: begin
                baud_next = '0;
                if (start) begin
                    state_next = START;
                    shift_next = byte_in;
                end
            end
            START: begin
                if (last_tick) begin
                    state_next = DATA;
                    bit_next   = '0;
                end
            end
            DATA: begin
                if (last_tick) begin
                    shift_next = shift_reg >> 1;
                    if (bit_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (start) begin
                        state_next = START;
                        shift_next = byte_in;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            START:   tx = 1'b0;
            DATA:    tx = shift_reg[0];
            default: tx = 1'b1;
        endcase
    end

    assign idle = (state_reg == IDLE);
    assign done = (state_reg == STOP) && last_tick;

endmodule

// File: rtl/sigma_uart_tx.sv
// Sends each captured 12-bit accumulator sum as two UART bytes on tx.
// A one-entry holding register absorbs a sum arriving mid-frame; further arrivals raise ovf.
module sigma_uart_tx
    import sigma_pkg::*;
#(
    parameter int         CLK_DIV = 16,
    parameter logic [3:0] HDR     = HDR_DEFAULT
) (
    input  logic             clk,
    input  logic             res,
    input  logic [SUM_W-1:0] data_in,
    input  logic             syn_in,
    output logic             tx,
    output logic             busy,
    output logic             ovf
);

    localparam logic LAST_BYTE = 1'(FRAME_BYTES - 1);

    logic             hold_full_reg, hold_full_next;
    logic [SUM_W-1:0] hold_data_reg, hold_data_next;
    logic [SUM_W-1:0] sum_reg, sum_next;
    logic             bsel_reg, bsel_next;
    logic             ovf_reg, ovf_next;

    logic              byte_idle, byte_done, byte_start;
    logic [BYTE_W-1:0] byte_data;
    logic              frame_end, start_frame;
    logic [SUM_W-1:0]  new_sum;

    uart_byte_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_byte_tx (
        .clk     (clk),
        .res     (res),
        .start   (byte_start),
        .byte_in (byte_data),
        .tx      (tx),
        .idle    (byte_idle),
        .done    (byte_done)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hold_full_reg <= 1'b0;
            hold_data_reg <= '0;
            sum_reg       <= '0;
            bsel_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            hold_full_reg <= hold_full_next;
            hold_data_reg <= hold_data_next;
            sum_reg       <= sum_next;
            bsel_reg      <= bsel_next;
            ovf_reg       <= ovf_next;
        end
    end

    // A new frame may begin from idle or in the very last cycle of the previous frame;
    // the held sum always has priority over a fresh strobe.
    always_comb begin
        frame_end   = byte_done && (bsel_reg == LAST_BYTE);
        start_frame = (byte_idle || frame_end) && (syn_in || hold_full_reg);
        new_sum     = hold_full_reg ? hold_data_reg : data_in;
        byte_start  = start_frame || (byte_done && !frame_end);
        byte_data   = start_frame ? frame_byte(HDR, new_sum, 1'b0)
                                  : frame_byte(HDR, sum_reg, 1'b1);

        sum_next       = start_frame ? new_sum : sum_reg;
        bsel_next      = bsel_reg;
        hold_full_next = hold_full_reg;
        hold_data_next = hold_data_reg;
        ovf_next       = syn_in && hold_full_reg;

        if (start_frame || frame_end) begin
            bsel_next = 1'b0;
        end else if (byte_done) begin
            bsel_next = 1'b1;
        end

        if (start_frame && hold_full_reg) begin
            hold_full_next = 1'b0;
        end else if (syn_in && !hold_full_reg && !start_frame) begin
            hold_full_next = 1'b1;
            hold_data_next = data_in;
        end
    end

    assign busy = !byte_idle || hold_full_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_sigma_uart_tx.sv
// Directed bench for sigma_uart_tx: table of single sums plus hand-written
// back-to-back, edge-arrival, overflow and mid-frame reset sequences.
module tb_sigma_uart_tx;

    localparam int DIV       = 16;
    localparam int FRAME_CYC = 20 * DIV;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        syn_in = 1'b0;
    logic [11:0] data_in = 12'h000;
    logic        tx;
    logic        busy;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [11:0] sum;
        logic [7:0]  b0;
        logic [7:0]  b1;
    } vec_t;

    vec_t vecs [5];

    always #5 clk = ~clk;

    sigma_uart_tx #(
        .CLK_DIV (DIV),
        .HDR     (4'hA)
    ) dut (
        .clk     (clk),
        .res     (res),
        .data_in (data_in),
        .syn_in  (syn_in),
        .tx      (tx),
        .busy    (busy),
        .ovf     (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Expected line level for bit-time k (0..19) of a frame made of bytes b0, b1.
    function automatic logic exp_bit(input logic [7:0] b0, input logic [7:0] b1, input int k);
        logic [7:0] b;
        int p;
        b = (k < 10) ? b0 : b1;
        p = k % 10;
        if (p == 0) return 1'b0;
        if (p == 9) return 1'b1;
        return b[p-1];
    endfunction

    task automatic strobe(input logic [11:0] d);
        @(negedge clk);
        data_in = d;
        syn_in  = 1'b1;
        @(negedge clk);
        syn_in  = 1'b0;
    endtask

    // Strobes s1, optionally drives s2 / s3 at sample index d2 / d3 (-1 = never),
    // then checks the line against one or two frames with hand-computed bytes.
    task automatic run_seq(input string name, input logic [11:0] s1,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [11:0] s2, input int d2,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input logic [11:0] s3, input int d3,
                           input int frames);
        int         total;
        int         idx;
        int         bad_tx;
        int         busy_cnt;
        int         ovf_cnt;
        int         ovf_at;
        logic       e;
        logic [7:0] rx [4];
        total    = frames * FRAME_CYC + 40;
        bad_tx   = 0;
        busy_cnt = 0;
        ovf_cnt  = 0;
        ovf_at   = -1;
        for (int i = 0; i < 4; i++) rx[i] = 8'h00;
        strobe(s1);
        check({name, " latency busy"}, 32'(busy), 32'd1);
        for (int j = 0; j < total; j++) begin
            idx = j / DIV;
            if (idx < 20)                    e = exp_bit(e0, e1, idx);
            else if (idx < 40 && frames > 1) e = exp_bit(e2, e3, idx - 20);
            else                             e = 1'b1;
            if (tx !== e) bad_tx++;
            if (busy === 1'b1) busy_cnt++;
            if (ovf === 1'b1) begin
                ovf_cnt++;
                ovf_at = j;
            end
            if ((j % DIV) == DIV / 2 && idx < 40 && (idx % 10) >= 1 && (idx % 10) <= 8)
                rx[idx / 10][(idx % 10) - 1] = tx;
            syn_in = 1'b0;
            if (j == d2) begin
                syn_in  = 1'b1;
                data_in = s2;
            end
            if (j == d3) begin
                syn_in  = 1'b1;
                data_in = s3;
            end
            @(negedge clk);
        end
        syn_in = 1'b0;
        check({name, " tx bit errors"}, 32'(bad_tx), 32'd0);
        check({name, " rx byte0"}, 32'(rx[0]), 32'(e0));
        check({name, " rx byte1"}, 32'(rx[1]), 32'(e1));
        if (frames > 1) begin
            check({name, " rx byte2"}, 32'(rx[2]), 32'(e2));
            check({name, " rx byte3"}, 32'(rx[3]), 32'(e3));
        end
        check({name, " busy cycles"}, 32'(busy_cnt), 32'(frames * FRAME_CYC));
        check({name, " ovf pulses"}, 32'(ovf_cnt), (d3 >= 0) ? 32'd1 : 32'd0);
        if (d3 >= 0) check({name, " ovf cycle"}, 32'(ovf_at), 32'(d3 + 1));
        check({name, " end tx"}, 32'(tx), 32'd1);
        check({name, " end busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int bad_idle;

        vecs[0] = '{sum: 12'h020, b0: 8'hA0, b1: 8'h20};
        vecs[1] = '{sum: 12'hFFE, b0: 8'hAF, b1: 8'hFE};
        vecs[2] = '{sum: 12'h7FF, b0: 8'hA7, b1: 8'hFF};
        vecs[3] = '{sum: 12'h800, b0: 8'hA8, b1: 8'h00};
        vecs[4] = '{sum: 12'h5A5, b0: 8'hA5, b1: 8'hA5};

        repeat (3) @(negedge clk);
        check("reset tx", 32'(tx), 32'd1);
        check("reset busy", 32'(busy), 32'd0);
        check("reset ovf", 32'(ovf), 32'd0);
        res = 1'b1;

        bad_idle = 0;
        for (int j = 0; j < 1000; j++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) bad_idle++;
        end
        check("idle line samples", 32'(bad_idle), 32'd0);

        for (int v = 0; v < 5; v++) begin
            run_seq($sformatf("vec%0d", v), vecs[v].sum, vecs[v].b0, vecs[v].b1,
                    12'h000, -1, 8'h00, 8'h00, 12'h000, -1, 1);
            $display("vec%0d sum=%03h bytes=%02h %02h done", v, vecs[v].sum, vecs[v].b0, vecs[v].b1);
        end

        run_seq("b2b", 12'h020, 8'hA0, 8'h20, 12'h010, 39, 8'hA0, 8'h10, 12'h030, 79, 2);
        $display("back-to-back sequence done");

        run_seq("edge", 12'h020, 8'hA0, 8'h20, 12'h3C5, 319, 8'hA3, 8'hC5, 12'h000, -1, 2);
        $display("edge-arrival sequence done");

        run_seq("edgefull", 12'h123, 8'hA1, 8'h23, 12'h456, 100, 8'hA4, 8'h56, 12'h789, 319, 2);
        $display("edge-arrival with hold full sequence done");

        strobe(12'h020);
        repeat (20) @(negedge clk);
        strobe(12'h7FF);
        repeat (40) @(negedge clk);
        res = 1'b0;
        #1;
        check("midreset tx", 32'(tx), 32'd1);
        check("midreset busy", 32'(busy), 32'd0);
        check("midreset ovf", 32'(ovf), 32'd0);
        repeat (3) @(negedge clk);
        res = 1'b1;
        repeat (5) @(negedge clk);
        check("after reset tx", 32'(tx), 32'd1);
        check("after reset busy (hold empty)", 32'(busy), 32'd0);
        run_seq("postreset", 12'h5A5, 8'hA5, 8'hA5, 12'h000, -1, 8'h00, 8'h00, 12'h000, -1, 1);
        $display("mid-frame reset sequence done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sigma_uart_tx.md
# sigma_uart_tx

Serial output stage placed directly downstream of the 16-point accumulator (sigma_16p). It captures each 12-bit sum on the accumulator's `syn_out` pulse. It then transmits the sum as two UART 8N1 bytes on a single `tx` line. A one-deep holding register absorbs one sum that arrives while a frame is in flight; further arrivals are dropped and flagged.

## Interface
- `CLK_DIV`, default 16: clock cycles per UART bit. Minimum is 2.
- `HDR`, default 4'hA: header nibble placed in the upper half of byte 0.
- `clk`, input, 1 bit: the single clock; everything samples on the rising edge.
- `res`, input, 1 bit: reset, asynchronous and active-low (0 = reset).
- `data_in`, input, 12 bits: two's-complement sum, driven by the accumulator's `data_out`.
- `syn_in`, input, 1 bit: one-cycle strobe meaning `data_in` is valid, driven by the accumulator's `syn_out`.
- `tx`, output, 1 bit: UART line. Idles high.
- `busy`, output, 1 bit: high while a frame is being sent or the holding register is full.
- `ovf`, output, 1 bit: one-cycle pulse when a sum is dropped.

## Operation
- Frame per sum, two bytes in order:
  - byte 0 = {HDR, data_in[11:8]}
  - byte 1 = data_in[7:0]
- Each byte is sent as: start bit (0), 8 data bits LSB first, stop bit (1). That is 10 bit-times per byte, 20 per frame.
- Sign is carried in bit 11 unchanged. No sign-magnitude conversion is done in this block.
- FSM states: IDLE, START, DATA, STOP. A byte index `bsel` (0/1) and a bit counter (0..7) qualify DATA.
  - IDLE → START when `syn_in` is high or the holding register is full. Load the shift/frame register, set `bsel`=0.
  - START → DATA after CLK_DIV cycles.
  - DATA → STOP after 8 bit-times.
  - STOP with `bsel`=0 → START with `bsel`=1.
  - STOP with `bsel`=1 → START (new frame, `bsel`=0) if a pending sum exists, else IDLE.
- Holding register, one entry:
  - `syn_in` while FSM ≠ IDLE and hold empty: store the sum, set hold full.
  - `syn_in` while hold full: sum discarded, `ovf` pulses next cycle, hold keeps the older value.
- Simultaneous events:
  - `syn_in` in the last cycle of frame-final STOP with hold empty: the sum starts the next frame directly, with no idle gap.
  - The same case with hold full: the held sum is sent first, and the new sum is dropped with `ovf` asserted.
- `busy` = (state ≠ IDLE) or hold full.

## Timing
- Reset values: `tx`=1, `busy`=0, `ovf`=0, state IDLE, hold empty, all counters 0. Reset is asynchronous and takes effect immediately, including mid-frame; `tx` returns to 1 without finishing the byte.
- Capture latency: `syn_in` high at edge n means `tx` falls at edge n+1 and `busy`=1 from edge n+1.
- Each bit is held for exactly CLK_DIV cycles, counted by a baud counter that restarts at every START entry.
- Frame duration is 20·CLK_DIV cycles. `busy` falls at the edge ending byte-1 STOP when nothing is pending.
- Back-to-back frames have no gap between STOP and the next START.
- Bytes 0 and 1 are contiguous, with no idle bit-time between them.

## Structure
- Shared package `sigma_pkg`:
  - state enum (IDLE/START/DATA/STOP)
  - `SUM_W`=12
  - `BYTE_W`=8
  - `FRAME_BYTES`=2
  - default `HDR`
- Natural sub-module: `uart_byte_tx`, covering the baud counter, START/DATA/STOP sequencing of one byte, and a `done` pulse.
- The top level owns the holding register, byte selection and `ovf`.

## Test plan
- Single sum: `data_in`=12'h020 with one `syn_in` strobe, CLK_DIV=16. Required response:
  - `tx` sends 0xA0 then 0x20. Bit pattern after each start is 0,0,0,0,0,1,0,1 then 0,0,0,0,0,1,0,0.
  - Each bit lasts 16 cycles.
  - `busy` is high for 320 cycles.
- Negative sum: `data_in`=12'hFFE (-2) → bytes 0xAF, 0xFE. `ovf` stays 0.
- Back-to-back: strobes carrying 12'h020, then 12'h010 at +40 cycles, then 12'h030 at +80 cycles. Required response:
  - 12'h020 frame, then 12'h010 frame with no gap.
  - 12'h030 is dropped, with a single `ovf` pulse at +81 cycles.
  - Total `busy` = 640 cycles.
- Edge arrival: `syn_in` in the final STOP cycle with hold empty → the next start bit begins on the following edge, and `tx` never idles.
- Reset mid-frame: `res`=0 during the DATA bits of byte 0. Required response:
  - `tx`=1, `busy`=0 and hold empty immediately.
  - After `res`=1, a new strobe produces a clean, complete frame.
- Idle line: `syn_in`=0 for 1000 cycles after reset → `tx` stays 1, `busy` stays 0, `ovf` stays 0.
